// File: rtl/systolic_mm_array.sv
// systolic_mm_array: N x N output-stationary systolic matrix multiply (BOOL/WRAP/SAT/TROP)
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       op select latched on accepted start: 0 BOOL, 1 WRAP, 2 SAT, 3 TROP
//   start      begin an operation (IDLE only)
//   in_valid   a_in/b_in beat valid (FEED only)
//   in_ready   high while in FEED
//   a_in       column k of A, element i at [i*W +: W]
//   b_in       row k of B, element j at [j*W +: W]
//   out_valid  c_out valid (READ)
//   c_out      result element, row-major
//   busy       state != IDLE
//   done       one-cycle pulse after the last readout beat
//   ovf        sticky wrap/clamp flag when SYSTOLIC_OVF_FLAG_EN is defined, else 0
module systolic_mm_array #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int ACC_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     a_in,
    input  logic [N*W-1:0]     b_in,
    output logic               out_valid,
    output logic [ACC_W-1:0]   c_out,
    output logic               busy,
    output logic               done,
    output logic               ovf
);
    localparam int CW = $clog2(N*N);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, READ} state_t;
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      mode_q;
    logic            done_q;
    logic            go;
    logic            beat;
    assign go   = state_q == IDLE && start;
    assign beat = state_q == FEED && in_valid;
    // cnt_q counts accepted beats in FEED, drain cycles in DRAIN and the readout index in READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= FEED;
                    cnt_q   <= '0;
                    mode_q  <= mode;
                end
                FEED: if (in_valid) begin
                    cnt_q   <= cnt_q == CW'(N-1) ? '0 : cnt_q + 1'b1;
                    state_q <= cnt_q == CW'(N-1) ? DRAIN : FEED;
                end
                DRAIN: begin
                    cnt_q   <= cnt_q == CW'(2*N-2) ? '0 : cnt_q + 1'b1;
                    state_q <= cnt_q == CW'(2*N-2) ? READ : DRAIN;
                end
                READ: begin
                    cnt_q   <= cnt_q == CW'(N*N-1) ? '0 : cnt_q + 1'b1;
                    state_q <= cnt_q == CW'(N*N-1) ? IDLE : READ;
                    done_q  <= cnt_q == CW'(N*N-1);
                end
            endcase
        end
    end
    // Skew word {a_valid, a, b_valid, b}: row i of A and column i of B share the same i-cycle delay
    logic [2*W+1:0] sk [N];
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [2*W+1:0] x;
        assign x = {beat, a_in[i*W +: W], beat, b_in[i*W +: W]};
        if (i == 0) begin : g_direct
            assign sk[0] = x;
        end else begin : g_dly
            logic [2*W+1:0] d_q [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) d_q[s] <= '0;
                end else begin
                    d_q[0] <= x;
                    for (int s = 1; s < i; s++) d_q[s] <= d_q[s-1];
                end
            end
            assign sk[i] = d_q[i-1];
        end
    end
    // ar/br carry {valid, operand} between neighbouring cells; edge cells have no outgoing register
    logic [W:0]       ar  [N][N-1];
    logic [W:0]       br  [N-1][N];
    logic [ACC_W-1:0] acc [N*N];
`ifdef SYSTOLIC_OVF_FLAG_EN
    logic [N*N-1:0]   ov;
`endif
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [W:0]       ax;
            logic [W:0]       bx;
            logic             en;
            logic [2*W-1:0]   p;
            logic [ACC_W:0]   s;
            logic [W:0]       t;
            logic [ACC_W-1:0] tz;
            logic [ACC_W-1:0] acc_d;
            logic [ACC_W-1:0] acc_q;
            if (j == 0) begin : g_ain
                assign ax = sk[i][2*W+1:W+1];
            end else begin : g_anb
                assign ax = ar[i][j-1];
            end
            if (i == 0) begin : g_bin
                assign bx = sk[j][W:0];
            end else begin : g_bnb
                assign bx = br[i-1][j];
            end
            assign en = ax[W] & bx[W];
            assign p  = {{W{1'b0}}, ax[W-1:0]} * {{W{1'b0}}, bx[W-1:0]};
            // One extra bit exposes the carry used for both wrap detection and saturation
            assign s  = {1'b0, acc_q} + {{(ACC_W+1-2*W){1'b0}}, p};
            assign t  = {1'b0, ax[W-1:0]} + {1'b0, bx[W-1:0]};
            assign tz = {{(ACC_W-W-1){1'b0}}, t};
            assign acc_d = mode_q == 2'd0 ? {{(ACC_W-1){1'b0}}, acc_q[0] | (|(ax[W-1:0] & bx[W-1:0]))} :
                           mode_q == 2'd1 ? s[ACC_W-1:0] :
                           mode_q == 2'd2 ? (s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0]) :
                           (tz < acc_q ? tz : acc_q);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc_q <= '0;
                else if (go) acc_q <= mode == 2'd3 ? {ACC_W{1'b1}} : '0;
                else if (en) acc_q <= acc_d;
            end
            assign acc[i*N+j] = acc_q;
            if (j < N-1) begin : g_ar
                logic [W:0] ar_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) ar_q <= '0;
                    else ar_q <= ax;
                end
                assign ar[i][j] = ar_q;
            end
            if (i < N-1) begin : g_br
                logic [W:0] br_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) br_q <= '0;
                    else br_q <= bx;
                end
                assign br[i][j] = br_q;
            end
`ifdef SYSTOLIC_OVF_FLAG_EN
            assign ov[i*N+j] = en & s[ACC_W] & (mode_q == 2'd1 || mode_q == 2'd2);
`endif
        end
    end
`ifdef SYSTOLIC_OVF_FLAG_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (go) ovf_q <= 1'b0;
        else if (|ov) ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
    always_comb begin
        c_out = '0;
        for (int e = 0; e < N*N; e++)
            if (state_q == READ && cnt_q == CW'(e)) c_out = acc[e];
    end
    assign in_ready  = state_q == FEED;
    assign out_valid = state_q == READ;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
endmodule
